// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Memory-access stage of the RV32I core. Accepts one load/store per
// handshake, issues a single outstanding request on the data-memory bus,
// aligns and sign/zero-extends load data, and drives the register-file
// write port. Misaligned or illegal accesses are rejected without any
// bus activity.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   -> an ACCESS that sees no mem_ack for TIMEOUT_CYCLES cycles
//                is abandoned and reported through error/done.
//   undefined -> no counter is built; ACCESS waits for mem_ack forever.
//
// Ports
//   clock, reset_n            : clock, synchronous active-low reset
//   in_valid / in_ready       : request handshake from execute
//   is_store, funct3, address : access kind, size/sign, byte address
//   store_data, in_rd         : store source value, load destination
//   mem_req, mem_we           : bus request (held until ack), write enable
//   mem_addr, mem_wdata       : word address, lane-replicated store data
//   mem_wstrb                 : byte strobes (0000 for loads)
//   mem_ack, mem_rdata        : bus completion and read word
//   rd, data, reg_write       : register-file write port (one-cycle pulse)
//   done, error               : completion / rejection pulses

module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd,
    output logic [31:0] data,
    output logic        reg_write,
    output logic        done,
    output logic        error
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        isStore_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [4:0]  pendRd_q;
    logic [31:0] memAddr_q;
    logic [31:0] memWdata_q;
    logic [3:0]  memWstrb_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;

    logic        reqIllegal;
    logic        reqMisaligned;
    logic        reqReject;
    logic [3:0]  wstrbD;
    logic [31:0] wdataD;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadValue;
    logic        timeoutHit;

    // Legality of the request presented at the input this cycle. funct3
    // 011 and 11x have no load/store meaning; the unsigned forms exist
    // only for loads.
    always_comb begin
        reqIllegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                        || (is_store && funct3[2]);
        reqMisaligned = ((funct3[1:0] == 2'b01) && address[0])
                        || ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        reqReject     = reqIllegal || reqMisaligned;
    end

    // Store lane placement: data is replicated across the word so the
    // strobes alone pick the bytes memory actually writes.
    always_comb begin
        wstrbD = 4'b0000;
        wdataD = 32'h0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrbD = 4'b0001 << address[1:0];
                    wdataD = {4{store_data[7:0]}};
                end
                2'b01: begin
                    wstrbD = address[1] ? 4'b1100 : 4'b0011;
                    wdataD = {2{store_data[15:0]}};
                end
                2'b10: begin
                    wstrbD = 4'b1111;
                    wdataD = store_data;
                end
                default: begin
                    wstrbD = 4'b0000;
                    wdataD = 32'h0;
                end
            endcase
        end
    end

    // Load extraction from the returned word, using the latched access
    // kind and lane. The result is only ever captured into a register.
    always_comb begin
        loadByte = mem_rdata[8*lane_q +: 8];
        loadHalf = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  loadValue = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadValue = {24'h0, loadByte};
            3'b001:  loadValue = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadValue = {16'h0, loadHalf};
            default: loadValue = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] waitCnt_q;

    // Counts ACCESS cycles without ack; held at zero outside ACCESS so
    // every new access starts from a clean count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            waitCnt_q <= '0;
        end else if (state_q != ACCESS) begin
            waitCnt_q <= '0;
        end else if (!mem_ack) begin
            waitCnt_q <= waitCnt_q + 1'b1;
        end
    end

    // The cycle whose un-acked edge would bring the count to the limit.
    assign timeoutHit = (waitCnt_q == TLAST);
`else
    assign timeoutHit = 1'b0;
`endif

    // Next-state logic. An ack always takes priority over a timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = reqReject ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = RESP;
                end else if (timeoutHit) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and bus/writeback registers. Bus fields are
    // only loaded for legal requests, so a rejected access never disturbs
    // them; rd/data change only when a load completes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            isStore_q  <= 1'b0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            pendRd_q   <= 5'd0;
            memAddr_q  <= 32'h0;
            memWdata_q <= 32'h0;
            memWstrb_q <= 4'b0000;
            rd_q       <= 5'd0;
            data_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                isStore_q <= is_store;
                funct3_q  <= funct3;
                lane_q    <= address[1:0];
                pendRd_q  <= in_rd;
                if (!reqReject) begin
                    memAddr_q  <= {address[31:2], 2'b00};
                    memWdata_q <= wdataD;
                    memWstrb_q <= wstrbD;
                end
            end
            if (state_q == ACCESS && mem_ack && !isStore_q) begin
                rd_q   <= pendRd_q;
                data_q <= loadValue;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && isStore_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_wstrb = memWstrb_q;
    assign rd        = rd_q;
    assign data      = data_q;
    assign reg_write = (state_q == RESP) && !isStore_q && (rd_q != 5'd0);
    assign done      = (state_q == RESP) || (state_q == ERR);
    assign error     = (state_q == ERR);

endmodule
